// File: rtl/demux16_pkg.sv
// demux16_pkg: shared definitions for the 16-way serial-to-parallel path.
//   N      : assembled word width
//   SEL_W  : bit index width, log2(N)
//   state_e: deserializer FSM states (FILL collects bits, HOLD offers the word)
package demux16_pkg;
  localparam int N     = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;
endpackage

// File: rtl/demux1to16_dec.sv
// demux1to16_dec: SEL_W-to-N one-hot decoder with enable.
//   en     : when low, no output is asserted
//   sel    : index to decode
//   onehot : onehot[sel] = en, all other bits 0
module demux1to16_dec #(
  parameter int N     = demux16_pkg::N,
  parameter int SEL_W = demux16_pkg::SEL_W
) (
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [N-1:0]     onehot
);
  for (genvar i = 0; i < N; i++) begin : g_dec
    assign onehot[i] = en && (sel == SEL_W'(i));
  end
endmodule

// File: rtl/demux16_deser.sv
// demux16_deser: serial (LSB first) to 16-bit parallel deserializer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous frame abort (drops partial word / pending output)
//   in_valid/in_bit/in_ready : serial bit input handshake
//   bit_idx    : word position the next accepted bit is written to
//   out_valid/out_word/out_ready : assembled word output handshake
// All outputs are registers or decodes of the state register.
module demux16_deser #(
  parameter int N     = demux16_pkg::N,
  parameter int SEL_W = demux16_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic [SEL_W-1:0] bit_idx,
  output logic             out_valid,
  output logic [N-1:0]     out_word,
  input  logic             out_ready
);
  import demux16_pkg::*;

  state_e         state, state_nxt;
  logic [N-1:0]   word;
  logic [N-1:0]   we;
  logic           accept;

  assign in_ready  = (state == FILL);
  assign out_valid = (state == HOLD);
  assign out_word  = word;
  assign accept    = in_valid && in_ready;

  // one write enable per word bit; only the bit at bit_idx is touched
  demux1to16_dec #(.N(N), .SEL_W(SEL_W)) u_dec (
    .en     (accept),
    .sel    (bit_idx),
    .onehot (we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL: if (accept && bit_idx == SEL_W'(N-1)) state_nxt = HOLD;
      HOLD: if (out_ready)                          state_nxt = FILL;
      default:                                      state_nxt = FILL;
    endcase
    if (clear) state_nxt = FILL;
  end

  // index wraps modulo N, so the last accept leaves it at 0 for the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      bit_idx <= '0;
    else if (clear)  bit_idx <= '0;
    else if (accept) bit_idx <= bit_idx + 1'b1;
  end

  // word is not cleared on handoff: stale bits are overwritten as the next
  // frame fills, and out_valid is low meanwhile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     word <= '0;
    else if (clear) word <= '0;
    else begin
      for (int i = 0; i < N; i++)
        if (we[i]) word[i] <= in_bit;
    end
  end
endmodule

// File: tb/tb_demux16_deser.sv
module tb_demux16_deser;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        in_ready;
  logic [3:0]  bit_idx;
  logic        out_valid;
  logic [15:0] out_word;
  logic        out_ready = 1'b0;

  int nvec = 0;
  int nerr = 0;
  int cyc_n = 0;
  int rise_a, rise_b;
  logic prev_valid = 1'b0;

  // reference: frame progress as a bit count, a hold flag and the word image
  bit          m_hold;
  int          m_cnt;
  logic [15:0] m_acc;

  typedef struct {
    logic iv, ib, ordy, clr;
    logic e_rdy, e_vld;
    logic [3:0]  e_idx;
    logic [15:0] e_word;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  demux16_deser dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .bit_idx(bit_idx), .out_valid(out_valid), .out_word(out_word),
    .out_ready(out_ready)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold = 0; m_cnt = 0; m_acc = '0;
  endtask

  task automatic model_step(input logic iv, ib, ordy, clr);
    if (clr) model_reset();
    else if (!m_hold) begin
      if (iv) begin
        m_acc[m_cnt] = ib;
        m_cnt++;
        if (m_cnt == 16) begin m_cnt = 0; m_hold = 1; end
      end
    end else if (ordy) m_hold = 0;
  endtask

  task automatic chk_model();
    chk("in_ready",  {15'b0, in_ready},  {15'b0, !m_hold});
    chk("out_valid", {15'b0, out_valid}, {15'b0, m_hold});
    chk("bit_idx",   {12'b0, bit_idx},   16'(m_cnt));
    chk("out_word",  out_word,           m_acc);
  endtask

  // one clock: drive, edge, advance model, sample 1 ns after the edge
  task automatic cyc(input logic iv, ib, ordy, clr);
    in_valid = iv; in_bit = ib; out_ready = ordy; clear = clr;
    @(posedge clk);
    model_step(iv, ib, ordy, clr);
    #1;
    cyc_n++;
    if (out_valid && !prev_valid) begin rise_a = rise_b; rise_b = cyc_n; end
    prev_valid = out_valid;
    chk_model();
  endtask

  // send a word LSB first; gap_pct = chance of an idle cycle before each bit
  task automatic send_word(input logic [15:0] w, input int gap_pct, input logic ordy);
    for (int i = 0; i < 16; i++) begin
      while ($urandom_range(99) < gap_pct) cyc(1'b0, 1'($urandom), ordy, 1'b0);
      cyc(1'b1, w[i], ordy, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] w;
    model_reset();
    rise_a = 0; rise_b = 0;

    // reset state while held in reset
    #1;
    chk("rst in_ready",  {15'b0, in_ready},  16'h1);
    chk("rst out_valid", {15'b0, out_valid}, 16'h0);
    chk("rst bit_idx",   {12'b0, bit_idx},   16'h0);
    chk("rst out_word",  out_word,           16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (5) cyc(1'b0, 1'b1, 1'b1, 1'b0);

    // table: single frame 16'h3F0A, continuous valid, out_ready high
    w = 16'h3F0A;
    for (int i = 0; i < 16; i++)
      tbl.push_back('{1'b1, w[i], 1'b1, 1'b0,
                      (i != 15), (i == 15), 4'((i + 1) % 16),
                      w & 16'((32'h1 << (i + 1)) - 1)});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, w}); // handoff, bit ignored
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, w}); // word retained
    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].iv; in_bit = tbl[i].ib; out_ready = tbl[i].ordy; clear = tbl[i].clr;
      @(posedge clk);
      model_step(tbl[i].iv, tbl[i].ib, tbl[i].ordy, tbl[i].clr);
      #1;
      chk("tbl in_ready",  {15'b0, in_ready},  {15'b0, tbl[i].e_rdy});
      chk("tbl out_valid", {15'b0, out_valid}, {15'b0, tbl[i].e_vld});
      chk("tbl bit_idx",   {12'b0, bit_idx},   {12'b0, tbl[i].e_idx});
      chk("tbl out_word",  out_word,           tbl[i].e_word);
    end
    prev_valid = out_valid;

    // loopback via a scanned mux (sel 0..15), two frames back-to-back
    w = 16'h3F0A;
    for (int s = 0; s < 16; s++) cyc(1'b1, w[s], 1'b1, 1'b0);
    chk("loop word1", out_word, 16'h3F0A);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);           // handoff; bit not accepted
    w = 16'hA5C3;
    for (int s = 0; s < 16; s++) cyc(1'b1, w[s], 1'b1, 1'b0);
    chk("loop word2", out_word, 16'hA5C3);
    chk("frame period", 16'(rise_b - rise_a), 16'd17);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // stalls + backpressure: 1,0x14,1 -> 8001
    send_word(16'h8001, 40, 1'b0);
    repeat (10) cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
    chk("bp word", out_word, 16'h8001);
    chk("bp in_ready", {15'b0, in_ready}, 16'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // clear with a simultaneous valid bit after 7 bits
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("clr bit_idx", {12'b0, bit_idx}, 16'h0);
    chk("clr word", out_word, 16'h0);
    send_word(16'hFFFF, 0, 1'b1);
    chk("clr next word", out_word, 16'hFFFF);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // async reset while in HOLD, between edges
    send_word(16'h1234, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async out_valid", {15'b0, out_valid}, 16'h0);
    chk("async in_ready",  {15'b0, in_ready},  16'h1);
    chk("async out_word",  out_word,           16'h0);
    @(negedge clk) rst_n = 1'b1;
    prev_valid = 1'b0;
    send_word(16'hC0DE, 20, 1'b1);
    chk("post-rst word", out_word, 16'hC0DE);

    // random traffic against the model
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(3) != 0), 1'($urandom), 1'($urandom_range(2) != 0),
          1'($urandom_range(40) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
